// File: rtl/dm_access_arbiter.sv
// Two-port arbiter for the single-port data memory: arbitrates, merges sub-word stores, extends loads and flags bad accesses.
// Latency: ack arrives in the cycle after the request is sampled in IDLE, so there is at most one access every 2 cycles.
// Backpressure: a requester holds req with stable fields until its ack. The loser keeps waiting and is re-sampled in the next IDLE.
module dm_access_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_sext,
    input  logic [11:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_sext,
    input  logic [11:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic [9:0]  m_addr,
    output logic [31:0] m_wd,
    output logic        m_we,
    input  logic [31:0] m_rd
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        win_q, win_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;

    logic        sel;
    logic [1:0]  sel_size;
    logic [11:0] sel_addr;

    // Pick a winner, latch its access and step the two-state sequencer
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_d        = win_q;
        we_d         = we_q;
        size_d       = size_q;
        sext_d       = sext_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;

        // On a tie, round-robin hands the grant to the port that did not go last.
        if (p0_req && p1_req) begin
            sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            sel = p1_req;
        end
        sel_size = sel ? p1_size : p0_size;
        sel_addr = sel ? p1_addr : p0_addr;

        if (state_q == S_IDLE) begin
            if (p0_req || p1_req) begin
                win_d   = sel;
                we_d    = sel ? p1_we    : p0_we;
                size_d  = sel_size;
                sext_d  = sel ? p1_sext  : p0_sext;
                addr_d  = sel_addr;
                wdata_d = sel ? p1_wdata : p0_wdata;
                err_d   = (sel_size == 2'b11)
                        | ((sel_size == 2'b01) & sel_addr[0])
                        | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00));
                state_d = S_ACCESS;
            end
        end else begin
            last_grant_d = win_q;
            state_d      = S_IDLE;
        end
    end

    // Sequencer and latched-access registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sext_q       <= 1'b0;
            addr_q       <= 12'h000;
            wdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_q        <= win_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
        end
    end

    logic        in_access;
    logic        live;
    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [31:0] rd_b;
    logic [31:0] rd_h;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic [31:0] rd_out;

    // Big-endian lane select, read-merge-write data, load extension and per-port outputs
    always_comb begin
        in_access = (state_q == S_ACCESS);
        // A reset asserted during ACCESS cancels both the write and the ack.
        live      = in_access & rst_n;
        // Byte offset 0 is the top lane, so the shift is (3 - offset) bytes.
        sh_b      = {~addr_q[1:0], 3'b000};
        sh_h      = {~addr_q[1], 4'b0000};
        rd_b      = m_rd >> sh_b;
        rd_h      = m_rd >> sh_h;

        case (size_q)
            2'b00:   merged = (m_rd & ~(32'h0000_00FF << sh_b)) | ({24'h0, wdata_q[7:0]} << sh_b);
            2'b01:   merged = (m_rd & ~(32'h0000_FFFF << sh_h)) | ({16'h0, wdata_q[15:0]} << sh_h);
            default: merged = wdata_q;
        endcase

        case (size_q)
            2'b00:   load_val = {{24{sext_q & rd_b[7]}}, rd_b[7:0]};
            2'b01:   load_val = {{16{sext_q & rd_h[15]}}, rd_h[15:0]};
            default: load_val = m_rd;
        endcase

        rd_out   = (live & ~we_q & ~err_q) ? load_val : 32'h0;

        m_addr   = addr_q[11:2];
        m_wd     = in_access ? merged : wdata_q;
        m_we     = live & we_q & ~err_q;

        p0_ack   = live & ~win_q;
        p1_ack   = live & win_q;
        p0_err   = p0_ack & err_q;
        p1_err   = p1_ack & err_q;
        p0_rdata = win_q ? 32'h0 : rd_out;
        p1_rdata = win_q ? rd_out : 32'h0;
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
module tb_dm_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_sext, p1_req, p1_we, p1_sext;
    logic [1:0]  p0_size, p1_size;
    logic [11:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [9:0]  m_addr;
    logic [31:0] m_wd, m_rd;
    logic        m_we;

    // Second instance for fixed priority; its data path is inert.
    logic        fp_p0_req, fp_p1_req;
    logic        fp_we, fp_sext;
    logic [1:0]  fp_size;
    logic [11:0] fp_addr;
    logic [31:0] fp_wdata, fp_m_rd;
    logic        fp_p0_ack, fp_p0_err, fp_p1_ack, fp_p1_err, fp_m_we;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_m_wd;
    logic [9:0]  fp_m_addr;

    logic [31:0] mem [0:1023];
    logic        mem_clr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dm_access_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sext(p0_sext),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sext(p1_sext),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd)
    );

    dm_access_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(fp_p0_req), .p0_we(fp_we), .p0_size(fp_size), .p0_sext(fp_sext),
        .p0_addr(fp_addr), .p0_wdata(fp_wdata), .p0_ack(fp_p0_ack), .p0_rdata(fp_p0_rdata), .p0_err(fp_p0_err),
        .p1_req(fp_p1_req), .p1_we(fp_we), .p1_size(fp_size), .p1_sext(fp_sext),
        .p1_addr(fp_addr), .p1_wdata(fp_wdata), .p1_ack(fp_p1_ack), .p1_rdata(fp_p1_rdata), .p1_err(fp_p1_err),
        .m_addr(fp_m_addr), .m_wd(fp_m_wd), .m_we(fp_m_we), .m_rd(fp_m_rd)
    );

    // Single-port memory model: combinational read, write on the rising edge.
    assign m_rd = mem[m_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (m_we) begin
            mem[m_addr] <= m_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Raise req in an IDLE cycle, wait (bounded) for ack, capture results, return to IDLE.
    task automatic do_acc(input int port, input logic we, input logic [1:0] size, input logic sext,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output logic other_ack, output int lat);
        logic got = 1'b0;
        int n = 0;
        rd = 32'h0; er = 1'b0; other_ack = 1'b0;
        if (port == 0) begin
            p0_we = we; p0_size = size; p0_sext = sext; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_size = size; p1_sext = sext; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        while (!got && n < 6) begin
            @(posedge clk); #1;
            n++;
            if ((port == 0) ? p0_ack : p1_ack) got = 1'b1;
        end
        if (got) begin
            rd        = (port == 0) ? p0_rdata : p1_rdata;
            er        = (port == 0) ? p0_err   : p1_err;
            other_ack = (port == 0) ? p1_ack   : p0_ack;
            lat       = n;
        end else begin
            lat = 99;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] rd;
        logic        er, oth;
        int          lat;
        logic [1:0]  rr_exp [8];
        logic [1:0]  fp_exp [7];

        vecs[0]  = '{0, 1'b1, 2'b10, 1'b0, 12'h010, 32'h12345678, 32'h0,        1'b0}; // sw
        vecs[1]  = '{0, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h12345678, 1'b0}; // lw
        vecs[2]  = '{1, 1'b1, 2'b00, 1'b0, 12'h012, 32'h000000AB, 32'h0,        1'b0}; // sb
        vecs[3]  = '{1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h1234AB78, 1'b0}; // lw
        vecs[4]  = '{0, 1'b0, 2'b00, 1'b1, 12'h012, 32'h0,        32'hFFFFFFAB, 1'b0}; // lb
        vecs[5]  = '{1, 1'b0, 2'b00, 1'b0, 12'h012, 32'h0,        32'h000000AB, 1'b0}; // lbu
        vecs[6]  = '{0, 1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        32'hFFFFAB78, 1'b0}; // lh
        vecs[7]  = '{0, 1'b0, 2'b01, 1'b0, 12'h010, 32'h0,        32'h00001234, 1'b0}; // lhu
        vecs[8]  = '{0, 1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        32'h00000078, 1'b0}; // lb off 3
        vecs[9]  = '{0, 1'b1, 2'b01, 1'b0, 12'h011, 32'h0000FFFF, 32'h0,        1'b1}; // sh misaligned
        vecs[10] = '{1, 1'b0, 2'b10, 1'b0, 12'h012, 32'h0,        32'h0,        1'b1}; // lw misaligned
        vecs[11] = '{0, 1'b0, 2'b11, 1'b0, 12'h010, 32'h0,        32'h0,        1'b1}; // illegal size
        vecs[12] = '{1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'h1234AB78, 1'b0}; // lw unchanged

        rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        fp_exp = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10};

        p0_req = 0; p0_we = 0; p0_size = 0; p0_sext = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_sext = 0; p1_addr = 0; p1_wdata = 0;
        fp_p0_req = 0; fp_p1_req = 0; fp_we = 0; fp_sext = 0; fp_size = 2'b10;
        fp_addr = 0; fp_wdata = 0; fp_m_rd = 0;
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset acks",   32'({p1_ack, p0_ack}), 32'h0);
        check("reset errs",   32'({p1_err, p0_err}), 32'h0);
        check("reset rdata",  p0_rdata | p1_rdata, 32'h0);
        check("reset m_addr", 32'(m_addr), 32'h0);
        check("reset m_wd",   m_wd, 32'h0);
        check("reset m_we",   32'(m_we), 32'h0);
        rst_n = 1'b1; mem_clr = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            do_acc(vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                   rd, er, oth, lat);
            check($sformatf("vec%0d ack latency", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d other ack", i), 32'(oth), 32'h0);
            if (!vecs[i].we) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
        end
        check("mem word4 after errs", mem[4], 32'h1234AB78);

        // Round-robin: both ports hold req; last grant was port 1.
        p0_we = 0; p0_size = 2'b10; p0_addr = 12'h010;
        p1_we = 0; p1_size = 2'b10; p1_addr = 12'h010;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("rr cycle%0d acks", i + 2), 32'({p1_ack, p0_ack}), 32'(rr_exp[i]));
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;

        // Fixed priority: port 0 always wins until it drops req.
        fp_p0_req = 1'b1; fp_p1_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check($sformatf("fp cycle%0d acks", i + 2), 32'({fp_p1_ack, fp_p0_ack}), 32'(fp_exp[i]));
            if (i == 4) fp_p0_req = 1'b0;
        end
        fp_p1_req = 1'b0;
        @(posedge clk); #1;

        // Reset during ACCESS must suppress both the write and the ack.
        do_acc(0, 1'b1, 2'b10, 1'b0, 12'h020, 32'h55AA55AA, rd, er, oth, lat);
        check("pre-store word8", mem[8], 32'h55AA55AA);
        p0_we = 1'b1; p0_size = 2'b10; p0_addr = 12'h020; p0_wdata = 32'hDEADBEEF; p0_req = 1'b1;
        @(posedge clk); #1;
        check("access m_addr", 32'(m_addr), 32'h8);
        rst_n = 1'b0; p0_req = 1'b0;
        #1;
        check("mid-reset m_we", 32'(m_we), 32'h0);
        check("mid-reset ack",  32'({p1_ack, p0_ack}), 32'h0);
        @(posedge clk); #1;
        check("word8 unchanged",     mem[8], 32'h55AA55AA);
        check("post-reset m_addr",   32'(m_addr), 32'h0);
        check("post-reset m_wd",     m_wd, 32'h0);
        check("post-reset ack/err",  32'({p1_ack, p0_ack, p1_err, p0_err}), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset ack", 32'({p1_ack, p0_ack}), 32'h0);
        check("idle after reset m_we", 32'(m_we), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
